led_blink_bank: RTL and testbench

Parametrised multi-channel LED driver. It replaces the hand-written per-LED toggle counters in the top level with one shared prescaler and NCHAN independent channels. Each channel runs in one of four modes: off, on, periodic blink, or retriggerable one-shot pulse. The block sits in the `sys_clk` domain and drives the board `LED` vector as status and heartbeat indication.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_channel.sv | 81 ++++++++
 rtl/led_blink_bank.sv | 50 +++++
 tb/tb_led_blink_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types for the LED blink bank
package led_pkg;

   // Per-channel operating mode, encoded as it appears on the mode input bus
   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PULSE = 2'd3
   } led_mode_t;

   localparam int MODE_W = 2;

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: off, on, periodic blink or retriggerable pulse
import led_pkg::*;

module led_channel #(
   parameter int CNT_W = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             tick,
   input  led_mode_t        mode,
   input  logic [CNT_W-1:0] period,
   input  logic             trig,
   output logic             led
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_cnt;
   logic             terminal;
   logic             led_q;
   led_mode_t        mode_q;

   // A period of zero behaves as one tick; >= lets a shrunken period wrap on the next tick
   always_comb begin
      last_cnt = (period == '0) ? '0 : period - CNT_W'(1);
      terminal = (cnt >= last_cnt);
   end

   // Channel state: a mode change restarts the channel and masks that cycle's tick/trig
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt    <= '0;
         led_q  <= 1'b0;
         mode_q <= LED_OFF;
      end else if (mode != mode_q) begin
         cnt    <= '0;
         led_q  <= (mode == LED_ON);
         mode_q <= mode;
      end else begin
         case (mode_q)
            LED_OFF: begin
               cnt   <= '0;
               led_q <= 1'b0;
            end
            LED_ON: begin
               cnt   <= '0;
               led_q <= 1'b1;
            end
            LED_BLINK: begin
               if (tick) begin
                  if (terminal) begin
                     cnt   <= '0;
                     led_q <= ~led_q;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            LED_PULSE: begin
               if (trig) begin
                  cnt   <= '0;
                  led_q <= 1'b1;
               end else if (led_q && tick) begin
                  if (terminal) begin
                     cnt   <= '0;
                     led_q <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               cnt   <= '0;
               led_q <= 1'b0;
            end
         endcase
      end
   end

   assign led = led_q;

endmodule

// File: rtl/led_blink_bank.sv
// rtl/led_blink_bank.sv - shared tick prescaler feeding NCHAN independent LED channels
import led_pkg::*;

module led_blink_bank #(
   parameter int NCHAN    = 4,
   parameter int PRESCALE = 100000,
   parameter int CNT_W    = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [2*NCHAN-1:0]     mode,
   input  logic [CNT_W*NCHAN-1:0] period,
   input  logic [NCHAN-1:0]       trig,
   output logic [NCHAN-1:0]       led,
   output logic                   tick
);

   localparam int PCNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [PCNT_W-1:0] pcnt;
   logic              wrap;

   assign wrap = (pcnt == PCNT_W'(PRESCALE - 1));

   // Prescaler: tick is a registered strobe on the edge where pcnt wraps to zero
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else begin
         tick <= wrap;
         pcnt <= wrap ? '0 : pcnt + PCNT_W'(1);
      end
   end

   for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      led_channel #(
         .CNT_W (CNT_W)
      ) u_channel (
         .sys_clk (sys_clk),
         .sys_rst (sys_rst),
         .tick    (tick),
         .mode    (led_mode_t'(mode[MODE_W*g +: MODE_W])),
         .period  (period[CNT_W*g +: CNT_W]),
         .trig    (trig[g]),
         .led     (led[g])
      );
   end

endmodule

// File: tb/tb_led_blink_bank.sv
// tb/tb_led_blink_bank.sv - self-checking bench for led_blink_bank
module tb_led_blink_bank;

   localparam int NCHAN    = 4;
   localparam int PRESCALE = 4;
   localparam int CNT_W    = 16;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [2*NCHAN-1:0]     mode = '0;
   logic [CNT_W*NCHAN-1:0] period = '0;
   logic [NCHAN-1:0]       trig = '0;
   logic [NCHAN-1:0]       led;
   logic                   tick;

   int vectors = 0;
   int miscompares = 0;

   // reference model: edges since reset release, ticks counted per channel, expected outputs
   int             n;
   int             ph [NCHAN];
   int             mq [NCHAN];
   logic [NCHAN-1:0] exp_led;
   logic           exp_tick;

   always #5 clk = ~clk;

   led_blink_bank #(
      .NCHAN    (NCHAN),
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .mode    (mode),
      .period  (period),
      .trig    (trig),
      .led     (led),
      .tick    (tick)
   );

   task automatic set_mode(input int ch, input int m);
      mode[2*ch +: 2] = m[1:0];
   endtask

   task automatic set_period(input int ch, input int p);
      period[CNT_W*ch +: CNT_W] = p[CNT_W-1:0];
   endtask

   task automatic model_reset();
      n = 0;
      exp_led = '0;
      exp_tick = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         ph[i] = 0;
         mq[i] = 0;
      end
   endtask

   // One rising edge of the reference: tick is a pure function of the edge count
   task automatic model_edge();
      bit tk;
      int md;
      int eff;
      tk = (n > 0) && (n % PRESCALE == 0);
      n++;
      exp_tick = (n % PRESCALE == 0);
      for (int i = 0; i < NCHAN; i++) begin
         md  = int'(mode[2*i +: 2]);
         eff = int'(period[CNT_W*i +: CNT_W]);
         if (eff == 0) eff = 1;
         if (md != mq[i]) begin
            mq[i] = md;
            ph[i] = 0;
            exp_led[i] = (md == 1);
         end else if (md == 0) begin
            exp_led[i] = 1'b0;
         end else if (md == 1) begin
            exp_led[i] = 1'b1;
         end else if (md == 2) begin
            if (tk) begin
               ph[i] = ph[i] + 1;
               if (ph[i] >= eff) begin
                  ph[i] = 0;
                  exp_led[i] = ~exp_led[i];
               end
            end
         end else begin
            if (trig[i]) begin
               exp_led[i] = 1'b1;
               ph[i] = 0;
            end else if (exp_led[i] && tk) begin
               ph[i] = ph[i] + 1;
               if (ph[i] >= eff) begin
                  ph[i] = 0;
                  exp_led[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag);
      vectors++;
      assert (tick === exp_tick) else begin
         miscompares++;
         $error("FAIL %s tick=%b expected %b (edge %0d)", tag, tick, exp_tick, n);
      end
      vectors++;
      assert (led === exp_led) else begin
         miscompares++;
         $error("FAIL %s led=%b expected %b (edge %0d)", tag, led, exp_led, n);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check(tag);
   endtask

   initial begin
      int last0, last1, tog0, tog1, bound, w;
      logic p0, p1, prev;

      // reset state
      model_reset();
      repeat (2) @(negedge clk);
      check("reset");
      rst = 1'b0;
      repeat (13) step("idle_tick");

      // BLINK: ch0 period 3, ch1 period 0 (behaves as 1)
      set_period(0, 3);
      set_period(1, 0);
      set_mode(0, 2);
      set_mode(1, 2);
      last0 = -1; last1 = -1; tog0 = 0; tog1 = 0;
      for (int k = 0; k < 140; k++) begin
         p0 = led[0];
         p1 = led[1];
         step("blink");
         if (led[0] !== p0) begin
            if (last0 >= 0) begin
               vectors++;
               assert (k - last0 === 3 * PRESCALE) else begin
                  miscompares++;
                  $error("FAIL blink_p3_interval got %0d expected %0d", k - last0, 3 * PRESCALE);
               end
            end
            last0 = k;
            tog0++;
         end
         if (led[1] !== p1) begin
            if (last1 >= 0) begin
               vectors++;
               assert (k - last1 === PRESCALE) else begin
                  miscompares++;
                  $error("FAIL blink_p0_interval got %0d expected %0d", k - last1, PRESCALE);
               end
            end
            last1 = k;
            tog1++;
         end
      end
      vectors++;
      assert (tog0 >= 10) else begin
         miscompares++;
         $error("FAIL blink_p3_toggles got %0d expected >= 10", tog0);
      end

      // BLINK period shrink 10 -> 2 while cnt = 7
      set_period(1, 10);
      bound = 0;
      while (ph[1] != 7 && bound < 200) begin
         step("shrink_wait");
         bound++;
      end
      vectors++;
      assert (ph[1] == 7) else begin
         miscompares++;
         $error("FAIL shrink_reach_cnt7 got %0d expected 7", ph[1]);
      end
      set_period(1, 2);
      prev = led[1];
      repeat (PRESCALE) step("shrink");
      vectors++;
      assert (led[1] === ~prev) else begin
         miscompares++;
         $error("FAIL shrink_toggle led1=%b expected %b", led[1], ~prev);
      end

      // PULSE: ch2 period 2
      set_period(2, 2);
      set_mode(2, 3);
      step("pulse_mode");
      trig[2] = 1'b1;
      step("pulse_trig");
      trig[2] = 1'b0;
      vectors++;
      assert (led[2] === 1'b1) else begin
         miscompares++;
         $error("FAIL pulse_rise led2=%b expected 1", led[2]);
      end
      w = 1;
      while (led[2] === 1'b1 && w < 20) begin
         step("pulse_width");
         if (led[2] === 1'b1) w++;
      end
      vectors++;
      assert (w >= 5 && w <= 8) else begin
         miscompares++;
         $error("FAIL pulse_width got %0d expected 5..8", w);
      end

      // retrigger while high
      trig[2] = 1'b1;
      step("retrig_a");
      trig[2] = 1'b0;
      repeat (3) step("retrig_mid");
      trig[2] = 1'b1;
      step("retrig_b");
      trig[2] = 1'b0;
      repeat (10) step("retrig_tail");

      // trig coincident with terminal tick
      trig[2] = 1'b1;
      step("coinc_trig");
      trig[2] = 1'b0;
      bound = 0;
      while (!(exp_led[2] && ph[2] == 1 && n % PRESCALE == 0) && bound < 20) begin
         step("coinc_wait");
         bound++;
      end
      vectors++;
      assert (bound < 20) else begin
         miscompares++;
         $error("FAIL coinc_reach bound=%0d expected < 20", bound);
      end
      trig[2] = 1'b1;
      step("coinc");
      trig[2] = 1'b0;
      vectors++;
      assert (led[2] === 1'b1) else begin
         miscompares++;
         $error("FAIL coinc_hold led2=%b expected 1", led[2]);
      end
      repeat (10) step("coinc_tail");

      // ch3 BLINK -> ON mid-count
      set_period(3, 5);
      set_mode(3, 2);
      repeat (7) step("ch3_blink");
      set_mode(3, 1);
      step("ch3_on");
      vectors++;
      assert (led[3] === 1'b1) else begin
         miscompares++;
         $error("FAIL ch3_on led3=%b expected 1", led[3]);
      end
      repeat (3) step("ch3_hold");

      // async reset mid-pulse
      trig[2] = 1'b1;
      step("rst_trig");
      trig[2] = 1'b0;
      repeat (2) step("rst_mid");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (20) step("after_reset");

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 29) == 0) set_mode(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 39) == 0) set_period(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
         for (int c = 0; c < NCHAN; c++) trig[c] = ($urandom_range(0, 9) == 0);
         step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
